// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressable 32-bit data memory for the RV32 load/store path.
// Byte/half/word accesses with byte enables, sign/zero extension on loads,
// registered read (1-cycle latency) and valid/ready handshakes on both sides.
// Misaligned or illegal accesses are reported through rsp_err and never write.
//
// Memory contents are undefined until written.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready;
// a response transfers on a rising edge where rsp_valid & rsp_ready. Once
// rsp_valid is high, rsp_rdata/rsp_err hold steady until the response transfers.
module data_mem_lsu #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = $clog2(DEPTH) + 2,
    parameter     INIT_FILE = "ram.hex"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    logic [31:0]       mem [DEPTH];

    logic [0:0]        state;
    logic              accept;
    logic              acc_err;
    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;

    // Registered read word plus the attributes needed to extract/extend it.
    logic [31:0]       rd_word;
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic              r_uns;
    logic              r_load;
    logic [31:0]       shifted;
    logic [31:0]       ext_data;

    assign word_idx  = req_addr[ADDR_W-1:2];
    assign lane      = req_addr[1:0];
    assign req_ready = (state == ST_IDLE) | ((state == ST_RESP) & rsp_ready);
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (state == ST_RESP);

    // Alignment/size legality, byte enables and lane-replicated store data.
    always_comb begin
        acc_err   = 1'b0;
        be        = 4'hF;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                acc_err   = lane[0];
                be        = 4'b0011 << lane;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                acc_err   = (lane != 2'b00);
            end
            default: begin
                acc_err   = 1'b1;
            end
        endcase
    end

    // Array port: byte-enabled write and synchronous read at the accept edge.
    // The read sees the pre-edge contents, so a load returns old data.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            if (req_we && !acc_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                    end
                end
            end
            if (!req_we) begin
                rd_word <= mem[word_idx];
            end
        end
    end

    // Handshake FSM and response attribute registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            r_load  <= 1'b0;
            rsp_err <= 1'b0;
            r_size  <= 2'b10;
            r_lane  <= 2'b00;
            r_uns   <= 1'b0;
        end else if (accept) begin
            state   <= ST_RESP;
            r_load  <= !req_we && !acc_err;
            rsp_err <= acc_err;
            r_size  <= req_size;
            r_lane  <= lane;
            r_uns   <= req_unsigned;
        end else if ((state == ST_RESP) && rsp_ready) begin
            state   <= ST_IDLE;
            r_load  <= 1'b0;
            rsp_err <= 1'b0;
        end
    end

    // Move the selected byte/half to bit 0 and extend; stores/errors read as 0.
    always_comb begin
        shifted  = rd_word >> {r_lane, 3'b000};
        ext_data = rd_word;
        case (r_size)
            2'b00:   ext_data = r_uns ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ext_data = r_uns ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: ext_data = rd_word;
        endcase
        rsp_rdata = r_load ? ext_data : 32'h0;
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: vector table driven through a request
// task, scoreboard queue compared at each response transfer, plus hand-written
// sequences for backpressure, back-to-back throughput and reset.
module tb_data_mem_lsu;

  localparam int DEPTH = 1024;
  localparam int AW    = 12;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  data_mem_lsu #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];   // {err, rdata}
  logic [32:0] mon_e;
  int acc_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) acc_cnt++;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata=0x%08h err=%0b required none", rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e[32]});
        chk("rsp_rdata", rsp_rdata, mon_e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input logic [32:0] exp, output int stalls);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    stalls       = 0;
    @(negedge clk);
    while (!req_ready && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 for %0d cycles required 1", stalls);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses required 0", exp_q.size());
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs[20];
  int   nvec = 0;

  function automatic void add_vec(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [AW-1:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_rdata, input logic exp_err);
    vecs[nvec] = '{we, size, uns, addr, wdata, exp_rdata, exp_err};
    nvec++;
  endfunction

  // ---------------- test ----------------
  initial begin
    int st;
    int stall_sum;
    int c0;
    int a0;
    logic [31:0] d;

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Known value at 0x40 for the later reset test.
    issue(1'b1, 2'b10, 1'b0, 12'h040, 32'hCAFEF00D, 33'h0, st);
    req_valid = 1'b0;

    // store word then loads
    add_vec(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0);
    add_vec(1'b0, 2'b00, 1'b0, 12'h013, 32'h0,        32'hFFFFFFDE, 1'b0);
    add_vec(1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        32'h000000DE, 1'b0);
    add_vec(1'b0, 2'b01, 1'b0, 12'h012, 32'h0,        32'hFFFFDEAD, 1'b0);
    add_vec(1'b0, 2'b01, 1'b1, 12'h010, 32'h0,        32'h0000BEEF, 1'b0);
    add_vec(1'b0, 2'b10, 1'b1, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0);
    // byte and half stores
    add_vec(1'b1, 2'b10, 1'b0, 12'h020, 32'h00000000, 32'h00000000, 1'b0);
    add_vec(1'b1, 2'b00, 1'b0, 12'h021, 32'h12345678, 32'h00000000, 1'b0);
    add_vec(1'b1, 2'b01, 1'b0, 12'h022, 32'hAAAA5555, 32'h00000000, 1'b0);
    add_vec(1'b0, 2'b10, 1'b0, 12'h020, 32'h0,        32'h55557800, 1'b0);
    add_vec(1'b0, 2'b00, 1'b0, 12'h021, 32'h0,        32'h00000078, 1'b0);
    // misaligned and illegal
    add_vec(1'b1, 2'b10, 1'b0, 12'h030, 32'h11111111, 32'h00000000, 1'b0);
    add_vec(1'b1, 2'b01, 1'b0, 12'h031, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    add_vec(1'b1, 2'b10, 1'b0, 12'h032, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    add_vec(1'b0, 2'b11, 1'b0, 12'h030, 32'h0,        32'h00000000, 1'b1);
    add_vec(1'b1, 2'b11, 1'b0, 12'h030, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    add_vec(1'b0, 2'b01, 1'b0, 12'h033, 32'h0,        32'h00000000, 1'b1);
    add_vec(1'b0, 2'b10, 1'b0, 12'h030, 32'h0,        32'h11111111, 1'b0);

    for (int i = 0; i < nvec; i++) begin
      issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
            {vecs[i].exp_err, vecs[i].exp_rdata}, st);
    end
    req_valid = 1'b0;
    drain();

    // backpressure: response held for 3 cycles while the next request waits
    rsp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, {1'b0, 32'hDEADBEEF}, st);
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 12'h020;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
      chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 12'h020, 32'h0, {1'b0, 32'h55557800}, st);
    chk("bp_release_stalls", 32'(st), 32'h0);
    issue(1'b0, 2'b01, 1'b1, 12'h010, 32'h0, {1'b0, 32'h0000BEEF}, st);
    chk("bp_follow_stalls", 32'(st), 32'h0);
    req_valid = 1'b0;
    drain();

    // back-to-back alternating SW/LW to one address
    stall_sum = 0;
    c0 = cyc;
    a0 = acc_cnt;
    for (int k = 0; k < 4; k++) begin
      d = (32'($urandom_range(65535, 0)) << 16) | 32'($urandom_range(65535, 0));
      issue(1'b1, 2'b10, 1'b0, 12'h050, d, 33'h0, st);
      stall_sum += st;
      issue(1'b0, 2'b10, 1'b0, 12'h050, 32'h0, {1'b0, d}, st);
      stall_sum += st;
    end
    req_valid = 1'b0;
    chk("b2b_stalls", 32'(stall_sum), 32'h0);
    chk("b2b_accepts", 32'(acc_cnt - a0), 32'd8);
    chk("b2b_cycles", 32'(cyc - c0), 32'd8);
    drain();

    // reset mid-RESP with a store presented during reset
    rsp_ready    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_addr     = 12'h040;
    req_valid    = 1'b1;
    @(negedge clk);
    chk("rr_load_accept", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_we    = 1'b1;
    req_wdata = 32'h0BADBAD0;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("rr_pending_valid", {31'h0, rsp_valid}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("rr_valid_dropped", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rr_post_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rr_post_err", {31'h0, rsp_err}, 32'h0);
    @(posedge clk);
    #1;
    issue(1'b0, 2'b10, 1'b0, 12'h040, 32'h0, {1'b0, 32'hCAFEF00D}, st);
    req_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
